// File: rtl/uart_buf_pkg.sv
// Shared types and defaults for the UART byte-buffer scheduler.
package uart_buf_pkg;

  localparam int DATA_W          = 8;
  localparam int ADDR_W_DEF      = 8;
  localparam int DEPTH_DEF       = 256;
  localparam int TIMEOUT_CYC_DEF = 50000000;
  localparam int TMO_W_DEF       = 26;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_REQ  = 3'd1,
    ST_RX_CAP  = 3'd2,
    ST_TX_ADDR = 3'd3,
    ST_TX_DATA = 3'd4
  } state_e;

endpackage

// File: rtl/uart_idle_timer.sv
// Idle timer: counts while enabled, clears otherwise or on clr,
// and flags the terminal count (TIMEOUT_CYC-1).
module uart_idle_timer #(
  parameter int TIMEOUT_CYC = 50000000,
  parameter int TMO_W       = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count only while enabled.
  always_comb begin
    cnt_d = '0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TMO_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TMO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_ram_scheduler.sv
// Moves bytes RX FIFO -> RAM (drain) and RAM -> TX FIFO (replay),
// owning the single RAM port and both FIFO handshakes.
module uart_ram_scheduler
  import uart_buf_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TMO_W       = TMO_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdempty,
  input  logic              rx_rdfull,
  output logic              rx_rdreq,
  input  logic [DATA_W-1:0] rx_q,
  input  logic              tx_wrfull,
  output logic              tx_wrreq,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  input  logic              play_start,
  output logic              busy,
  output logic [ADDR_W:0]   byte_count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              play_pend_q, play_pend_d;
  logic              ovf_q, ovf_d;

  logic tmr_en, tmr_clr, tmr_tc;
  logic drain_trig, ram_full, last_byte;

  // Drain when full, or when bytes have waited a full timeout period.
  assign drain_trig = rx_rdfull || (tmr_tc && !rx_rdempty);
  assign tmr_en     = (state_q == ST_IDLE) && !rx_rdempty && !rx_rdfull;
  assign tmr_clr    = (state_q == ST_IDLE) && drain_trig;
  assign ram_full   = (cnt_q >= DEPTH_C);
  assign last_byte  = (({1'b0, rd_ptr_q} + (ADDR_W+1)'(1)) == cnt_q);

  uart_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMO_W       (TMO_W)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      play_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      play_pend_q <= play_pend_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next state: drain beats replay in IDLE; replay runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (drain_trig) begin
          state_d = ST_RX_REQ;
        end else if ((play_pend_q || play_start) && (cnt_q != '0)) begin
          state_d = ST_TX_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RX_REQ:  state_d = ST_RX_CAP;
      ST_RX_CAP:  state_d = rx_rdempty ? ST_IDLE : ST_RX_REQ;
      ST_TX_ADDR: state_d = ST_TX_DATA;
      ST_TX_DATA: begin
        if (tx_wrfull) begin
          state_d = ST_TX_DATA;
        end else if (last_byte) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TX_ADDR;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Pointer, count, pending-replay and overflow updates.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    play_pend_d = play_pend_q;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // A request arriving as a drain starts must survive the drain.
        if (drain_trig && play_start) begin
          play_pend_d = 1'b1;
        end else begin
          play_pend_d = play_pend_q;
        end
      end
      ST_RX_REQ: begin
        if (play_start) begin
          play_pend_d = 1'b1;
        end else begin
          play_pend_d = play_pend_q;
        end
      end
      ST_RX_CAP: begin
        if (play_start) begin
          play_pend_d = 1'b1;
        end else begin
          play_pend_d = play_pend_q;
        end
        if (!ram_full) begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          cnt_d    = cnt_q + (ADDR_W+1)'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      ST_TX_DATA: begin
        if (tx_wrfull) begin
          rd_ptr_d = rd_ptr_q;
        end else if (last_byte) begin
          rd_ptr_d    = '0;
          wr_ptr_d    = '0;
          cnt_d       = '0;
          play_pend_d = 1'b0;
        end else begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        play_pend_d = play_pend_q;
      end
    endcase
  end

  // Handshake and RAM port outputs decoded from the current state.
  always_comb begin
    rx_rdreq  = 1'b0;
    tx_wrreq  = 1'b0;
    tx_data   = '0;
    ram_addr  = '0;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    case (state_q)
      ST_RX_REQ: rx_rdreq = 1'b1;
      ST_RX_CAP: begin
        if (!ram_full) begin
          ram_wren  = 1'b1;
          ram_addr  = wr_ptr_q;
          ram_wdata = rx_q;
        end else begin
          ram_wren  = 1'b0;
        end
      end
      ST_TX_ADDR: ram_addr = rd_ptr_q;
      ST_TX_DATA: begin
        // Address held while stalled so ram_q stays valid for the retry.
        ram_addr = rd_ptr_q;
        if (!tx_wrfull) begin
          tx_wrreq = 1'b1;
          tx_data  = ram_q;
        end else begin
          tx_wrreq = 1'b0;
        end
      end
      default: begin
        rx_rdreq = 1'b0;
      end
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign byte_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_ram_scheduler.sv
// Bench: FIFO/RAM environment models plus a transaction-level reference
// (every popped byte is stored in order or dropped when RAM is full;
// replay emits the stored bytes in order exactly once).
module tb_uart_ram_scheduler;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int TMO    = 100;
  localparam int FIFO_D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdempty = 1'b1;
  logic        rx_rdfull = 1'b0;
  logic [7:0]  rx_q = 8'h00;
  logic        tx_wrfull = 1'b0;
  logic [7:0]  ram_q = 8'h00;
  logic        play_start = 1'b0;
  logic        rx_rdreq, tx_wrreq, ram_wren, busy, overflow;
  logic [7:0]  tx_data, ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [ADDR_W:0]   byte_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  uart_ram_scheduler #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .TMO_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdempty(rx_rdempty), .rx_rdfull(rx_rdfull),
    .rx_rdreq(rx_rdreq), .rx_q(rx_q), .tx_wrfull(tx_wrfull), .tx_wrreq(tx_wrreq),
    .tx_data(tx_data), .ram_addr(ram_addr), .ram_wren(ram_wren),
    .ram_wdata(ram_wdata), .ram_q(ram_q), .play_start(play_start), .busy(busy),
    .byte_count(byte_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- environment: RX FIFO and RAM ----------------
  logic [7:0] rxf[$];
  logic [7:0] pushq[$];
  logic [7:0] popped[$];
  logic       flush = 1'b0;
  logic [7:0] mem [0:15];

  always @(posedge clk) begin
    logic [7:0] b;
    if (rx_rdreq && rxf.size() > 0) begin
      b = rxf.pop_front();
      rx_q <= b;
      popped.push_back(b);
    end
    while (pushq.size() > 0 && rxf.size() < FIFO_D) rxf.push_back(pushq.pop_front());
    if (flush) begin
      rxf.delete();
      pushq.delete();
    end
    rx_rdempty <= (rxf.size() == 0);
    rx_rdfull  <= (rxf.size() >= FIFO_D);
  end

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  // ---------------- reference model and per-cycle compare ----------------
  int         m_cnt = 0;
  int         m_k = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] stored[$];
  int         wr_log[$];
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         rq_cyc = -1;
  int         fall_cyc = -1;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    logic [7:0] b;
    if (!rst_n) begin
      chk("reset_outputs", {rx_rdreq, tx_wrreq, ram_wren, busy, overflow, tx_data,
                            ram_addr, ram_wdata, byte_count}, 64'd0);
      m_cnt = 0; m_k = 0; m_ovf = 1'b0;
      stored.delete();
      popped.delete();
    end else begin
      chk("byte_count", byte_count, m_cnt);
      chk("overflow", overflow, m_ovf);
      if (rx_rdreq) begin
        chk("rdreq_while_empty", rx_rdempty, 1'b0);
        if (rq_cyc < 0) rq_cyc = cyc;
      end
      if (rx_rdreq || ram_wren || tx_wrreq) chk("busy_when_active", busy, 1'b1);
      if (prev_busy && !busy) fall_cyc = cyc;
      if (popped.size() > 0) begin
        b = popped.pop_front();
        if (m_cnt < DEPTH) begin
          chk("ram_wren", ram_wren, 1'b1);
          chk("ram_addr", ram_addr, m_cnt);
          chk("ram_wdata", ram_wdata, b);
          stored.push_back(b);
          wr_log.push_back(cyc);
          m_cnt++;
        end else begin
          chk("ram_wren_when_full", ram_wren, 1'b0);
          m_ovf = 1'b1;
        end
      end else begin
        chk("ram_wren_spurious", ram_wren, 1'b0);
      end
      if (tx_wrreq) begin
        chk("tx_wrreq_while_full", tx_wrfull, 1'b0);
        if (m_k < stored.size()) chk("tx_data", tx_data, stored[m_k]);
        else chk("tx_wrreq_nothing_stored", tx_wrreq, 1'b0);
        tx_log.push_back(tx_data);
        tx_cyc.push_back(cyc);
        m_k++;
        if (m_k >= m_cnt) begin
          m_cnt = 0; m_k = 0;
          stored.delete();
        end
      end
    end
    prev_busy = busy;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    wr_log.delete();
    tx_log.delete();
    tx_cyc.delete();
    rq_cyc = -1;
    fall_cyc = -1;
  endtask

  task automatic pulse_play();
    @(posedge clk); #1 play_start = 1'b1;
    @(posedge clk); #1 play_start = 1'b0;
  endtask

  task automatic wait_quiet(input string nm, input int max);
    int q = 0;
    int n = 0;
    while (q < 4 && n < max) begin
      @(negedge clk);
      n++;
      if (!busy && rx_rdempty && pushq.size() == 0) q++;
      else q = 0;
    end
    total++;
    if (q < 4) begin
      bad++;
      $display("FAIL %s: not quiet after %0d cycles", nm, max);
    end
  endtask

  logic [7:0] exp_b[$];
  int ne_cyc;
  int seen;

  initial begin
    // Reset and idle with an empty FIFO.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      chk("idle_outputs", {rx_rdreq, tx_wrreq, ram_wren, busy, overflow, tx_data,
                           ram_addr, ram_wdata, byte_count}, 64'd0);
    end

    // Full FIFO of 0x00..0x0F drains at 2 cycles per byte.
    clear_logs();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) pushq.push_back(8'(i));
    wait_quiet("drain_full", 200);
    chk("full_drain_writes", wr_log.size(), 16);
    for (int i = 1; i < wr_log.size(); i++) chk("write_spacing", wr_log[i] - wr_log[i-1], 2);
    for (int i = 0; i < 16; i++) chk("ram_content", mem[i], 8'(i));
    if (wr_log.size() > 0) chk("busy_fall_after_last_write", fall_cyc, wr_log[wr_log.size()-1] + 1);
    chk("byte_count_16", byte_count, 16);
    pulse_play();
    wait_quiet("replay_16", 200);
    chk("replay_16_len", tx_log.size(), 16);
    for (int i = 0; i < tx_log.size(); i++) chk("replay_16_data", tx_log[i], 8'(i));
    chk("byte_count_after_replay", byte_count, 0);

    // Three bytes, FIFO not full: timeout-forced drain.
    clear_logs();
    @(posedge clk); #1;
    pushq.push_back(8'hA1); pushq.push_back(8'hA2); pushq.push_back(8'hA3);
    @(posedge clk); @(negedge clk);
    chk("fifo_nonempty", rx_rdempty, 1'b0);
    ne_cyc = cyc;
    wait_quiet("timeout_drain", 300);
    chk("timeout_latency", rq_cyc - ne_cyc, TMO);
    chk("byte_count_3", byte_count, 3);

    // Replay with TX back-pressure right after the first write.
    clear_logs();
    pulse_play();
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (tx_wrreq) seen = 1;
    end
    chk("first_tx_seen", seen, 1);
    @(posedge clk); #1 tx_wrfull = 1'b1;
    repeat (5) @(posedge clk);
    #1 tx_wrfull = 1'b0;
    wait_quiet("replay_backpressure", 100);
    chk("bp_len", tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      chk("bp_byte0", tx_log[0], 8'hA1);
      chk("bp_byte1", tx_log[1], 8'hA2);
      chk("bp_byte2", tx_log[2], 8'hA3);
      chk("bp_stall_gap", tx_cyc[1] - tx_cyc[0], 6);
    end
    chk("byte_count_after_bp", byte_count, 0);

    // play_start in the same cycle the FIFO reports full.
    clear_logs();
    exp_b.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      exp_b.push_back(8'($urandom_range(0, 255)));
      pushq.push_back(exp_b[i]);
    end
    @(posedge clk); #1 play_start = 1'b1;
    chk("full_with_play", rx_rdfull, 1'b1);
    @(posedge clk); #1 play_start = 1'b0;
    wait_quiet("drain_then_replay", 400);
    chk("auto_replay_len", tx_log.size(), 16);
    for (int i = 0; i < tx_log.size() && i < 16; i++) chk("auto_replay_data", tx_log[i], exp_b[i]);
    if (tx_cyc.size() > 0 && wr_log.size() > 0)
      chk("replay_after_drain", tx_cyc[0] > wr_log[wr_log.size()-1], 1'b1);
    chk("byte_count_after_auto", byte_count, 0);

    // Overflow: 18 bytes into a 16-byte RAM.
    clear_logs();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) pushq.push_back(8'(8'h40 + i));
    repeat (4) @(posedge clk);
    #1 pushq.push_back(8'hEE); pushq.push_back(8'hEF);
    wait_quiet("overflow_drain", 300);
    chk("overflow_set", overflow, 1'b1);
    chk("overflow_count", byte_count, 16);
    chk("overflow_writes", wr_log.size(), 16);
    chk("overflow_fifo_empty", rx_rdempty, 1'b1);
    chk("overflow_last_kept", mem[15], 8'h4F);
    pulse_play();
    wait_quiet("overflow_replay", 200);
    chk("overflow_sticky", overflow, 1'b1);

    // Reset in the middle of a drain.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) pushq.push_back(8'($urandom_range(0, 255)));
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("mid_drain_reset", {rx_rdreq, tx_wrreq, ram_wren, busy, overflow, tx_data,
                               ram_addr, ram_wdata, byte_count}, 64'd0);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_count", byte_count, 0);

    // Randomized traffic, replay requests and TX back-pressure.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 9) == 0) begin
        for (int j = $urandom_range(1, 4); j > 0; j--)
          if (rxf.size() + pushq.size() < FIFO_D) pushq.push_back(8'($urandom_range(0, 255)));
      end
      play_start = ($urandom_range(0, 39) == 0);
      tx_wrfull  = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk); #1 play_start = 1'b0; tx_wrfull = 1'b0;
    wait_quiet("random_settle", 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_ram_scheduler.md
Name: uart_ram_scheduler

Overview:
Sequences the single-port 8-bit byte RAM between the UART receive FIFO and the UART transmit FIFO.
- Drains received bytes from the RX FIFO into RAM. A drain starts when the FIFO is full, or when bytes have sat unread for a timeout period.
- On command, replays the stored bytes in order into the TX FIFO.
- It is the only master of the RAM port and of the RX read and TX write handshakes.

Parameters:
ADDR_W, 8, RAM address width
DEPTH, 256, number of usable RAM bytes (≤ 2**ADDR_W)
TIMEOUT_CYC, 50000000, idle cycles with RX FIFO non-empty before a forced drain
TMO_W, 26, timeout counter width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock domain, asynchronous assertion, active-low
rx_rdempty  in  1  RX FIFO empty
rx_rdfull  in  1  RX FIFO full
rx_rdreq  out  1  RX FIFO read request; data is valid on rx_q the following cycle
rx_q  in  8  RX FIFO read data
tx_wrfull  in  1  TX FIFO full
tx_wrreq  out  1  TX FIFO write request
tx_data  out  8  TX FIFO write data
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_wdata  out  8  RAM write data
ram_q  in  8  RAM read data; 1-cycle latency from ram_addr
play_start  in  1  single-cycle pulse: replay the RAM contents to TX
busy  out  1  state != IDLE
byte_count  out  ADDR_W+1  bytes currently stored
overflow  out  1  sticky; set when a byte is dropped because RAM is full

Behaviour:
- Reset: all outputs 0; state IDLE; wr_ptr, rd_ptr, timeout counter and play_pend all 0.
- States: IDLE, RX_REQ, RX_CAP, TX_ADDR, TX_DATA.
- Drain trigger in IDLE: rx_rdfull=1, or timeout counter = TIMEOUT_CYC-1.
- Timeout counter:
  - Increments only when state is IDLE, rx_rdempty=0 and rx_rdfull=0.
  - Clears under any other condition.
  - Clears when the drain starts.
- IDLE priority: drain trigger > (play_pend or play_start) with byte_count>0 > stay.
- play_start received during RX_REQ/RX_CAP sets play_pend. play_start received during TX_* is ignored.
- RX_REQ: rx_rdreq=1 for exactly one cycle; next state is RX_CAP.
- RX_CAP:
  - If byte_count<DEPTH: ram_wren=1, ram_addr=wr_ptr, ram_wdata=rx_q; wr_ptr and byte_count increment.
  - Otherwise the byte is discarded, overflow is set to 1, and no write occurs.
  - Next state is RX_REQ if rx_rdempty=0, else IDLE.
  - Throughput is 2 cycles per byte.
- TX_ADDR: ram_addr=rd_ptr, ram_wren=0; next state is TX_DATA.
- TX_DATA (ram_q valid):
  - If tx_wrfull=0: tx_wrreq=1 for one cycle, tx_data=ram_q, rd_ptr increments.
    - If rd_ptr+1 = byte_count: go to IDLE and clear rd_ptr, wr_ptr, byte_count and play_pend.
    - Otherwise go to TX_ADDR.
  - If tx_wrfull=1: hold TX_DATA with ram_addr unchanged. There must be no duplicate or lost byte.
- Replay is never pre-empted. RX triggers that occur during replay wait until IDLE.
- ram_wren is asserted only in RX_CAP. rx_rdreq is never asserted while rx_rdempty=1 at RX_REQ entry.
- overflow is cleared only by reset.
- Reset asserted mid-operation: immediate return to the reset state. Partial RAM contents are abandoned; byte_count=0.

Decomposition:
- Shared package uart_buf_pkg:
  - state enum
  - DATA_W=8
  - default ADDR_W/DEPTH
  - TIMEOUT_CYC default
- One sub-module: uart_idle_timer (load/clear/enable counter, terminal-count pulse), parameterised by TIMEOUT_CYC and TMO_W.

Test Plan:
- Reset, then rx_rdempty=1 with no stimulus for 1000 cycles -> all outputs 0; busy stays 0.
- FIFO model holding 16 bytes 0x00..0x0F, rx_rdfull=1 -> 16 RAM writes at addr 0..15 with data 0x00..0x0F, 2 cycles apart; byte_count=16; busy falls the cycle after the last write.
- TIMEOUT_CYC=100, 3 bytes (0xA1,0xA2,0xA3) not full -> first rx_rdreq exactly 100 cycles after the FIFO becomes non-empty; byte_count=3.
- byte_count=3 then play_start; tx_wrfull=1 held 5 cycles after the first tx_wrreq -> tx_data sequence 0xA1,0xA2,0xA3 exactly once each; byte_count=0 afterwards.
- play_start in the same cycle as rx_rdfull -> drain completes first, then replay starts automatically and includes the newly stored bytes.
- DEPTH=4, 6 bytes drained -> 4 writes (addr 0..3), overflow=1, RX FIFO empty; assert rst_n=0 mid-drain -> outputs 0 immediately, byte_count=0.
